bcd_to_bin: RTL and testbench



---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_adjust.sv | 16 +
 rtl/bcd_to_bin.sv | 119 +++++++++++
 tb/tb_bcd_to_bin.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD <-> binary converters.
package bcd_pkg;

  // Converter FSM states; encodings 4..7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    ADJUST = 3'd2,
    DONE   = 3'd3
  } bcd_state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] ADJ_THRESH    = 4'd8;
  localparam logic [3:0] ADJ_VAL       = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction step for reverse double-dabble:
// a nibble that is 8 or more after a right shift is reduced by 3.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // Plain 4-bit subtract, no borrow into neighbouring digits.
  always_comb begin
    o_nib = i_nib;
    if (i_nib >= ADJ_THRESH) o_nib = i_nib - ADJ_VAL;
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
//
// Handshake: en is sampled only while the FSM is in IDLE; an accepted en
// starts a conversion of fixed length 8*NDIG cycles, busy is high for
// that whole span, and rdy pulses for one cycle afterwards with bin_d_out
// and err valid. en while busy is dropped. bin_d_out/err hold until the
// next rdy. dbg_state exposes the FSM state for checkers.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int NDIG  = 3,
  parameter int BIN_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [4*NDIG-1:0]   bcd_d_in,
  output logic [BIN_W-1:0]    bin_d_out,
  output logic                rdy,
  output logic                busy,
  output logic                err,
  output logic [2:0]          dbg_state
);

  localparam int W     = 4 * NDIG;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  // The output must be wide enough for the largest NDIG-digit decimal value.
  if ((64'd1 << BIN_W) <= (64'd10 ** NDIG - 64'd1)) begin : g_width_check
    $error("bcd_to_bin: BIN_W too small for NDIG digits");
  end

  bcd_state_e             r_state;
  logic [W-1:0]           r_bcd;
  logic [W-1:0]           r_bin;
  logic                   r_err;
  logic [CNT_W-1:0]       r_cnt;
  logic [BIN_W-1:0]       r_bin_out;
  logic                   r_err_out;
  logic                   r_rdy;

  logic [W-1:0]           w_adj;
  logic                   w_bad;
  logic [W+BIN_W-1:0]     w_bin_ext;
  logic                   w_ovf;

  // All digits are corrected in parallel.
  for (genvar d = 0; d < NDIG; d++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_nib (r_bcd[4*d +: 4]),
      .o_nib (w_adj[4*d +: 4])
    );
  end

  // Flag any non-decimal nibble on the incoming operand.
  always_comb begin
    w_bad = 1'b0;
    for (int d = 0; d < NDIG; d++) begin
      if (bcd_d_in[4*d +: 4] > BCD_MAX_DIGIT) w_bad = 1'b1;
    end
  end

  // Zero-extend so the result slice is legal for any BIN_W; bits above
  // BIN_W can only be set by an invalid operand, which already forces 0.
  assign w_bin_ext = {{BIN_W{1'b0}}, r_bin};
  assign w_ovf     = |(w_bin_ext >> BIN_W);

  // Conversion FSM: load, then alternate SHIFT/ADJUST, finish in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bcd     <= '0;
      r_bin     <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_bin_out <= '0;
      r_err_out <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_bcd   <= bcd_d_in;
            r_bin   <= '0;
            r_err   <= w_bad;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {1'b0, r_bcd, r_bin[W-1:1]};
          r_cnt          <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) r_state <= DONE;
          else                   r_state <= ADJUST;
        end
        ADJUST: begin
          r_bcd   <= w_adj;
          r_state <= SHIFT;
        end
        DONE: begin
          r_bin_out <= (r_err || w_ovf) ? '0 : w_bin_ext[BIN_W-1:0];
          r_err_out <= r_err;
          r_rdy     <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bin_d_out = r_bin_out;
  assign err       = r_err_out;
  assign rdy       = r_rdy;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed cases plus randomized
// operands compared against a decimal-arithmetic reference model.
module tb_bcd_to_bin;

  localparam int NDIG  = 3;
  localparam int BIN_W = 10;
  localparam int W     = 4 * NDIG;
  localparam int LAT   = 8 * NDIG;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [W-1:0]     bcd_d_in;
  logic [BIN_W-1:0] bin_d_out;
  logic             rdy;
  logic             busy;
  logic             err;
  logic [2:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int prev_bin = 0;
  int prev_err = 0;
  logic [BIN_W:0] exp_q[$];

  bcd_to_bin #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bcd_d_in  (bcd_d_in),
    .bin_d_out (bin_d_out),
    .rdy       (rdy),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    bcd_d_in = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: read the digits as a decimal number; any digit above 9
  // marks the operand invalid and the result becomes 0.
  function automatic logic [BIN_W:0] model(input logic [W-1:0] b);
    int v = 0;
    bit e = 0;
    logic [W-1:0] t = b;
    for (int d = NDIG - 1; d >= 0; d--) begin
      int dig = int'((t >> (4 * d)) & 'hF);
      if (dig > 9) e = 1;
      v = v * 10 + dig;
    end
    if (e) v = 0;
    return {e, BIN_W'(v)};
  endfunction

  // ---------------- drivers ----------------
  // One conversion; inj_cycle > 0 pulses a second en (to be ignored)
  // sampled at that edge.
  task automatic run_conv(input logic [W-1:0] v, input int inj_cycle, input logic [W-1:0] inj_val);
    int lat = -1;
    bit busy_ok = 1;
    bit hold_ok = 1;
    logic [BIN_W:0] exp;
    exp_q.push_back(model(v));
    @(negedge clk);
    bcd_d_in = v;
    en       = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    bcd_d_in = W'($urandom);
    for (int k = 1; k <= LAT + 8; k++) begin
      if (k == inj_cycle) begin
        en       = 1'b1;
        bcd_d_in = inj_val;
      end
      @(posedge clk);
      #1 en = 1'b0;
      if (rdy) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 0;
      if (bin_d_out !== BIN_W'(prev_bin) || err !== prev_err[0]) hold_ok = 0;
    end
    exp = exp_q.pop_front();
    check("latency", lat, LAT);
    check("busy_during", busy_ok, 1);
    check("out_hold", hold_ok, 1);
    check("bin_d_out", bin_d_out, exp[BIN_W-1:0]);
    check("err", err, exp[BIN_W]);
    check("busy_at_rdy", busy, 0);
    prev_bin = int'(exp[BIN_W-1:0]);
    prev_err = int'(exp[BIN_W]);
    @(posedge clk);
    #1 check("rdy_single", rdy, 0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    bit saw = 0;
    repeat (n) begin
      @(posedge clk);
      #1 if (rdy) saw = 1;
    end
    check(tag, saw, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    #1;
    check("rst_bin", bin_d_out, 0);
    check("rst_rdy", rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, 0);

    // Directed values
    run_conv(12'h999, 0, '0);
    run_conv(12'h000, 0, '0);
    run_conv(12'h512, 0, '0);
    run_conv(12'h001, 0, '0);
    run_conv(12'h9A3, 0, '0);
    run_conv(12'h250, 0, '0);

    // Second request while busy is dropped
    run_conv(12'h123, 5, 12'h456);
    expect_quiet("no_second_rdy", LAT + 6);

    // Reset mid-conversion aborts
    @(negedge clk);
    bcd_d_in = 12'h777;
    en       = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_bin", bin_d_out, 0);
    check("abort_busy", busy, 0);
    check("abort_rdy", rdy, 0);
    check("abort_err", err, 0);
    rst_n = 1'b1;
    prev_bin = 0;
    prev_err = 0;
    expect_quiet("abort_no_rdy", LAT + 6);
    run_conv(12'h042, 0, '0);

    // Back-to-back with en held high
    begin
      int cyc = 0;
      int last = 0;
      int pulses = 0;
      @(negedge clk);
      bcd_d_in = 12'h321;
      en       = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 80; i++) begin
        @(posedge clk);
        #1 cyc++;
        check("b2b_busy", busy, !rdy);
        if (rdy) begin
          check("b2b_interval", cyc - last, (pulses == 0) ? LAT : LAT + 1);
          check("b2b_bin", bin_d_out, 321);
          last = cyc;
          pulses++;
        end
      end
      check("b2b_pulses", pulses, 3);
      en = 1'b0;
      repeat (LAT + 4) @(posedge clk);
      #1;
      prev_bin = 321;
      prev_err = 0;
    end

    // Randomized operands, some with invalid nibbles
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] v;
      int inj;
      for (int d = 0; d < NDIG; d++) begin
        logic [3:0] nib;
        nib = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 9) == 0) nib = 4'($urandom_range(10, 15));
        v[4*d +: 4] = nib;
      end
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT - 1) : 0;
      run_conv(v, inj, W'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
